// File: rtl/iir_lpf_biquad.sv
// iir_lpf_biquad: direct-form-I biquad low-pass, one shared 32x16 multiplier.
// Define IIR_LPF_SAT_EN to clamp the rounded output instead of wrapping it.
module iir_lpf_biquad #(
  parameter logic signed [15:0] B0 = 16'sd1024,
  parameter logic signed [15:0] B1 = 16'sd2048,
  parameter logic signed [15:0] B2 = 16'sd1024,
  parameter logic signed [15:0] A1 = -16'sd16384,
  parameter logic signed [15:0] A2 = 16'sd4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [31:0] input_a,
  input  logic               input_a_stb,
  output logic               input_a_ack,
  output logic signed [31:0] output_z,
  output logic               output_z_stb,
  input  logic               output_z_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_RND,
    S_OUT,
    S_UPD
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_cnt;
  logic signed [31:0] r_x0;
  logic signed [31:0] r_x1;
  logic signed [31:0] r_x2;
  logic signed [31:0] r_y1;
  logic signed [31:0] r_y2;
  logic signed [51:0] r_acc;
  logic signed [31:0] r_z;
  logic               r_z_stb;
  logic               r_in_ack;

  logic signed [31:0] w_mx;
  logic signed [15:0] w_mc;
  logic signed [47:0] w_prod;
  logic signed [51:0] w_prod_ext;
  logic               w_sub;
  logic signed [31:0] w_z;
  logic               w_xfer;

  assign w_xfer = input_a_stb && r_in_ack;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_xfer) w_state_nxt = S_MAC;
      S_MAC:  if (r_cnt == 3'd4) w_state_nxt = S_RND;
      S_RND:  w_state_nxt = S_OUT;
      S_OUT:  if (output_z_ack) w_state_nxt = S_UPD;
      S_UPD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tap order B0,B1,B2,A1,A2; feedback taps are subtracted.
  always_comb begin
    w_mx = r_x0;
    w_mc = B0;
    unique case (r_cnt)
      3'd0: begin w_mx = r_x0; w_mc = B0; end
      3'd1: begin w_mx = r_x1; w_mc = B1; end
      3'd2: begin w_mx = r_x2; w_mc = B2; end
      3'd3: begin w_mx = r_y1; w_mc = A1; end
      default: begin w_mx = r_y2; w_mc = A2; end
    endcase
  end

  assign w_prod     = w_mx * w_mc;
  assign w_prod_ext = {{4{w_prod[47]}}, w_prod};
  assign w_sub      = (r_cnt >= 3'd3);

`ifdef IIR_LPF_SAT_EN
  logic signed [51:0] w_shr;
  assign w_shr = r_acc >>> 14;

  always_comb begin
    w_z = w_shr[31:0];
    if (w_shr > 52'sd2147483647)
      w_z = 32'sh7FFFFFFF;
    else if (w_shr < -52'sd2147483648)
      w_z = 32'sh80000000;
  end
`else
  assign w_z = r_acc[45:14];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_x0     <= '0;
      r_x1     <= '0;
      r_x2     <= '0;
      r_y1     <= '0;
      r_y2     <= '0;
      r_acc    <= '0;
      r_z      <= '0;
      r_z_stb  <= 1'b0;
      r_in_ack <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_in_ack <= (w_state_nxt == S_IDLE);
      r_z_stb  <= (w_state_nxt == S_OUT);
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_x0  <= input_a;
            r_acc <= '0;
            r_cnt <= 3'd0;
          end
        end
        S_MAC: begin
          r_acc <= w_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
          r_cnt <= r_cnt + 3'd1;
        end
        S_RND: r_z <= w_z;
        S_UPD: begin
          r_x2 <= r_x1;
          r_x1 <= r_x0;
          r_y2 <= r_y1;
          r_y1 <= r_z;
        end
        default: ;
      endcase
    end
  end

  assign input_a_ack  = r_in_ack;
  assign output_z     = r_z;
  assign output_z_stb = r_z_stb;

endmodule

// File: tb/tb_iir_lpf_biquad.sv
// tb_iir_lpf_biquad: directed and random checks against an arithmetic model.
// Build with IIR_LPF_SAT_EN to check the saturating variant.
module tb_iir_lpf_biquad;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [31:0] input_a = '0;
  logic               input_a_stb = 1'b0;
  logic               input_a_ack;
  logic signed [31:0] output_z;
  logic               output_z_stb;
  logic               output_z_ack = 1'b0;

  iir_lpf_biquad dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  localparam longint CB0 = 1024;
  localparam longint CB1 = 2048;
  localparam longint CB2 = 1024;
  localparam longint CA1 = -16384;
  localparam longint CA2 = 4096;

  longint hx1, hx2, hy1, hy2;

  function automatic void model_clear();
    hx1 = 0; hx2 = 0; hy1 = 0; hy2 = 0;
  endfunction

  // Exact difference equation in 64-bit, then floor shift and narrowing.
  function automatic int model(input int x);
    longint acc, s;
    int y;
    acc = CB0 * longint'(x) + CB1 * hx1 + CB2 * hx2 - CA1 * hy1 - CA2 * hy2;
    s = acc >>> 14;
`ifdef IIR_LPF_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    y = int'(s);
    hx2 = hx1; hx1 = longint'(x);
    hy2 = hy1; hy1 = longint'(y);
    return y;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    input_a_stb = 1'b0;
    output_z_ack = 1'b0;
    #1;
    chk("rst_z", int'(output_z), 0);
    chk("rst_stb", int'(output_z_stb), 0);
    chk("rst_ack", int'(input_a_ack), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ack_low", int'(input_a_ack), 0);
    @(negedge clk);
    chk("rel_ack_high", int'(input_a_ack), 1);
    model_clear();
  endtask

  task automatic wait_ack();
    int t;
    t = 0;
    while (input_a_ack !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("ack_wait", int'(t < 40), 1);
  endtask

  // early=1 holds output_z_ack and a junk input_a_stb while busy.
  task automatic xfer(input int x, input int stall, input bit early,
                      output int y);
    int e;
    wait_ack();
    input_a = x;
    input_a_stb = 1'b1;
    @(negedge clk);
    input_a_stb = early;
    input_a = $urandom;
    output_z_ack = early;
    chk("ack_drop", int'(input_a_ack), 0);
    e = 1;
    while (output_z_stb !== 1'b1 && e < 40) begin
      @(negedge clk);
      e++;
    end
    chk("latency", e, 7);
    y = model(x);
    chk("out", int'(output_z), y);
    input_a_stb = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_z", int'(output_z), y);
      chk("hold_ack", int'(input_a_ack), 0);
    end
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
    chk("stb_drop", int'(output_z_stb), 0);
    @(negedge clk);
    chk("ack_back", int'(input_a_ack), 1);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int saw;
    saw = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (output_z_stb === 1'b1) saw++;
    end
    chk(tag, saw, 0);
  endtask

  initial begin
    int y, x, st, tprev, tcur, e;
    bit early;

    do_reset();

    // impulse, with a 20-cycle stall on the second output
    xfer(16384, 0, 1'b0, y);
    chk("imp0", y, 1024);
    xfer(0, 20, 1'b0, y);
    chk("imp1", y, 3072);
    xfer(0, 0, 1'b0, y);
    chk("imp2", y, 3840);
    xfer(0, 0, 1'b0, y);

    // step response settles to unity gain
    do_reset();
    for (int i = 0; i < 200; i++) begin
      xfer(1000, 0, 1'b0, y);
      if (i >= 100) chk("step_range", int'(y >= 998 && y <= 1000), 1);
    end

    // throughput with both handshakes held high
    do_reset();
    output_z_ack = 1'b1;
    input_a_stb = 1'b1;
    tprev = 0;
    for (int i = 0; i < 6; i++) begin
      x = int'($urandom_range(0, 65535)) - 32768;
      input_a = x;
      wait_ack();
      @(negedge clk);
      tcur = cyc;
      if (i > 0) chk("period", tcur - tprev, 9);
      tprev = tcur;
      e = 0;
      while (output_z_stb !== 1'b1 && e < 40) begin
        @(negedge clk);
        e++;
      end
      chk("tp_wait", int'(e < 40), 1);
      y = model(x);
      chk("tp_out", int'(output_z), y);
    end
    input_a_stb = 1'b0;
    @(negedge clk);
    output_z_ack = 1'b0;

    // random samples, random stalls, early ack / junk strobe
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 3) x = int'($urandom);
      else x = int'($urandom_range(0, 2097151)) - 1048576;
      st = int'($urandom_range(0, 3));
      early = (st == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      xfer(x, st, early, y);
    end

    // reset mid-MAC aborts the sample and clears history
    wait_ack();
    input_a = 16384;
    input_a_stb = 1'b1;
    @(negedge clk);
    input_a_stb = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mac_rst_stb", int'(output_z_stb), 0);
    chk("mac_rst_z", int'(output_z), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("mac_rst_quiet", 12);
    model_clear();
    xfer(16384, 0, 1'b0, y);
    chk("mac_rst_imp", y, 1024);

    // reset during an output stall
    wait_ack();
    input_a = 5000;
    input_a_stb = 1'b1;
    @(negedge clk);
    input_a_stb = 1'b0;
    repeat (10) @(negedge clk);
    chk("stall_stb", int'(output_z_stb), 1);
    rst_n = 1'b0;
    #1;
    chk("out_rst_stb", int'(output_z_stb), 0);
    chk("out_rst_z", int'(output_z), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("out_rst_quiet", 12);
    model_clear();
    xfer(16384, 0, 1'b0, y);
    chk("out_rst_imp", y, 1024);

    // overflow: full-scale positive then full-scale negative run
    do_reset();
    for (int i = 0; i < 4; i++) xfer(32'sh7FFFFFFF, 0, 1'b0, y);
    for (int i = 0; i < 8; i++) xfer(32'sh80000000, 0, 1'b0, y);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
